// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared sizes, FSM encoding and drain length for the operand skew feeder
package systolic_feeder_pkg;
    localparam int BYTES_SIZE   = 8;
    localparam int N            = 16;
    localparam int DRAIN_CYCLES = 2 * N - 1;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: DEPTH-stage byte shift chain, one lane of the diagonal operand skew
module skew_line #(
    parameter int DEPTH = 1,
    parameter int BW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] in,
    output logic [BW-1:0] out
);
    logic [BW-1:0] sr [DEPTH];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else begin
            sr[0] <= in;
            for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
    end
    assign out = sr[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts A columns / B rows and emits lane-skewed byte streams, zero clear and done for the MAC array
module systolic_feeder #(
    parameter int N  = systolic_feeder_pkg::N,
    parameter int BW = systolic_feeder_pkg::BYTES_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*BW-1:0] in_a,
    input  logic [N*BW-1:0] in_b,
    input  logic          in_last,
    output logic [N*BW-1:0] left_out,
    output logic [N*BW-1:0] up_out,
    output logic          zero,
    output logic          done
);
    import systolic_feeder_pkg::*;
    state_t     state;
    logic [4:0] cnt;
    logic       acc;
    assign acc = in_valid && in_ready;
    // Non-accepted cycles feed zero bytes, which contribute nothing to PE sums
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.DEPTH(i + 1), .BW(BW)) u_a (
            .clk (clk),
            .rst (rst),
            .in  (acc ? in_a[N*BW-1-i*BW -: BW] : '0),
            .out (left_out[N*BW-1-i*BW -: BW])
        );
        skew_line #(.DEPTH(i + 1), .BW(BW)) u_b (
            .clk (clk),
            .rst (rst),
            .in  (acc ? in_b[N*BW-1-i*BW -: BW] : '0),
            .out (up_out[N*BW-1-i*BW -: BW])
        );
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
            zero     <= 1'b0;
            done     <= 1'b0;
        end else begin
            zero <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    state <= CLEAR;
                    zero  <= 1'b1;
                end
                CLEAR: begin
                    state    <= STREAM;
                    in_ready <= 1'b1;
                end
                STREAM: if (acc && in_last) begin
                    state    <= DRAIN;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                end
                DRAIN: if (cnt == 5'(DRAIN_CYCLES - 1)) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt + 5'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench with an attached 16x16 MAC array model checking skew, timing and sums
module tb_systolic_feeder;
    typedef struct {int cyc; int sig; int val;} item_t;
    logic clk = 0, rst = 0, in_valid = 0, in_last = 0;
    logic [127:0] in_a = '0, in_b = '0;
    logic in_ready, zero, done;
    logic [127:0] left_out, up_out;
    item_t q[$];
    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] ta [16][16], tb_m [16][16], es [16][16];
    logic [7:0] pa [16][16], pb [16][16], ps [16][16];
    logic [7:0] ain, bin;

    systolic_feeder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .left_out(left_out), .up_out(up_out), .zero(zero), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached array: PE(i,j) takes left from PE(i,j-1), up from PE(i-1,j), and accumulates mod 256
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    pa[i][j] <= 8'd0; pb[i][j] <= 8'd0; ps[i][j] <= 8'd0;
                end
        end else begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    ain = (j == 0) ? left_out[127-i*8 -: 8] : pa[i][(j==0)?0:j-1];
                    bin = (i == 0) ? up_out[127-j*8 -: 8] : pb[(i==0)?0:i-1][j];
                    pa[i][j] <= ain;
                    pb[i][j] <= bin;
                    ps[i][j] <= zero ? 8'd0 : 8'(ps[i][j] + ain * bin);
                end
        end
    end

    task automatic exp_at(input int c, input int s, input int v);
        q.push_back('{c, s, v});
    endtask

    function automatic int actual(input int s);
        if (s < 16) return int'(left_out[127-s*8 -: 8]);
        if (s < 32) return int'(up_out[127-(s-16)*8 -: 8]);
        if (s == 32) return int'(zero);
        if (s == 33) return int'(in_ready);
        if (s == 34) return int'(done);
        return int'(left_out == '0 && up_out == '0 && !zero && !done && !in_ready);
    endfunction

    always @(negedge clk) begin : mon
        bit dseen;
        int a, bi, bj;
        dseen = 0;
        for (int n = q.size() - 1; n >= 0; n--) begin
            if (q[n].cyc == cyc) begin
                checks++;
                if (q[n].sig == 35) begin
                    bi = -1; bj = -1;
                    for (int i = 0; i < 16; i++)
                        for (int j = 0; j < 16; j++)
                            if (ps[i][j] != es[i][j] && bi < 0) begin bi = i; bj = j; end
                    if (bi >= 0) begin
                        failures++;
                        $display("FAIL sums cycle=%0d pe(%0d,%0d) actual=%0h required=%0h",
                                 cyc, bi, bj, ps[bi][bj], es[bi][bj]);
                    end
                end else begin
                    a = actual(q[n].sig);
                    if (a != q[n].val) begin
                        failures++;
                        $display("FAIL sig%0d cycle=%0d actual=%0h required=%0h", q[n].sig, cyc, a, q[n].val);
                    end
                    if (q[n].sig == 34 && q[n].val == 1) dseen = 1;
                end
                q.delete(n);
            end
        end
        if (done && !dseen) begin
            checks++; failures++;
            $display("FAIL done_unexpected cycle=%0d actual=1 required=0", cyc);
        end
    end

    task automatic drive(input int k, input bit v, input bit last);
        in_valid = v;
        in_last  = last;
        for (int i = 0; i < 16; i++) begin
            in_a[127-i*8 -: 8] = v ? ta[i][k] : 8'hAA;
            in_b[127-i*8 -: 8] = v ? tb_m[k][i] : 8'h55;
        end
    endtask

    task automatic run_tile(input int kk, input logic [15:0] bub, input bit lanechk, input bit abort);
        int s, c, t, sum;
        bit acc, ok;
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                sum = 0;
                for (int k = 0; k < kk; k++) sum += int'(ta[i][k]) * int'(tb_m[k][j]);
                es[i][j] = 8'(sum);
            end
        s = cyc;
        exp_at(s + 1, 32, 1); exp_at(s + 1, 33, 0);
        exp_at(s + 2, 32, 0); exp_at(s + 2, 33, 1);
        for (int k = 0; k < kk; k++) begin
            if (bub[k]) begin
                drive(0, 0, 0);
                @(negedge clk);
            end
            ok = 0;
            for (t = 0; t < 8 && !ok; t++) begin
                drive(k, 1, k == kk - 1);
                acc = in_ready;
                c = cyc;
                if (acc && k == kk - 1) begin
                    if (!abort) begin
                        exp_at(c + 31, 34, 0); exp_at(c + 32, 34, 1); exp_at(c + 32, 35, 0);
                    end
                    if (lanechk) begin
                        exp_at(c + 1, 0, int'(ta[0][0]));   exp_at(c + 1, 16, int'(tb_m[0][0]));
                        exp_at(c + 15, 15, 0);              exp_at(c + 16, 15, int'(ta[15][0]));
                        exp_at(c + 17, 15, 0);              exp_at(c + 8, 23, int'(tb_m[0][7]));
                        exp_at(c + 9, 23, 0);
                    end
                end
                @(negedge clk);
                ok = acc;
            end
            if (!ok) begin
                checks++; failures++;
                $display("FAIL accept_timeout beat=%0d actual=0 required=1", k);
            end
        end
        drive(0, 0, 0);
        if (abort) begin
            repeat (10) @(negedge clk);
            @(posedge clk);
            #2 rst = 0;
            exp_at(cyc, 36, 1);
            repeat (3) begin
                @(negedge clk);
                exp_at(cyc + 1, 36, 1);
            end
            rst = 1;
        end else begin
            t = 0;
            while (!done && t < 60) begin @(negedge clk); t++; end
            if (!done) begin
                checks++; failures++;
                $display("FAIL done_timeout actual=0 required=1");
            end
        end
    endtask

    task automatic set_const(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin ta[i][j] = a; tb_m[i][j] = b; end
    endtask

    task automatic set_ident();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                ta[i][j] = (i == j) ? 8'd1 : 8'd0;
                tb_m[i][j] = 8'(i * 16 + j + 1);
            end
    endtask

    initial begin
        logic [15:0] mask;
        int b, nb;
        exp_at(1, 36, 1); exp_at(2, 36, 1);
        repeat (3) @(negedge clk);
        rst = 1;
        for (int n = 1; n <= 10; n++) exp_at(cyc + n, 36, 1);
        repeat (10) @(negedge clk);
        set_const(8'h01, 8'h02);
        run_tile(1, 16'h0, 1, 0);
        set_ident();
        run_tile(16, 16'h0, 0, 0);
        mask = '0; nb = 0;
        while (nb < 5) begin
            b = $urandom_range(15, 1);
            if (!mask[b]) begin mask[b] = 1'b1; nb++; end
        end
        run_tile(16, mask, 0, 0);
        set_const(8'h07, 8'h09);
        run_tile(1, 16'h0, 0, 1);
        set_const(8'h03, 8'h05);
        run_tile(1, 16'h0, 1, 0);
        set_ident();
        run_tile(16, 16'h0, 0, 0);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                ta[i][j] = 8'(i + j + 1);
                tb_m[i][j] = 8'(2 * j + i);
            end
        run_tile(2, 16'h0, 0, 0);
        repeat (5) @(negedge clk);
        foreach (q[n]) begin
            checks++; failures++;
            $display("FAIL unchecked sig%0d cycle=%0d actual=none required=%0h", q[n].sig, q[n].cyc, q[n].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
